// File: rtl/int_pri_queue_ctrl.sv
// Priority-queued vectored interrupt controller: level requests are armed, acked,
// queued per priority level, and handed to the CPU highest-level-first on a read strobe.

module int_pri_queue_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 11
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic          o_empty,
  output logic          o_full
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [PTR_W:0]   r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PTR_W'(1);
      if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + (PTR_W+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PTR_W+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is data-only; occupancy is fully described by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (PTR_W+1)'(DEPTH));
endmodule

module int_pri_queue_ctrl #(
  parameter int NUM_DEV = 8,
  parameter int PRI_W   = 3,
  parameter int DEPTH   = 4,
  parameter int VEC_W   = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_DEV-1:0]       i_req,
  input  logic [NUM_DEV*PRI_W-1:0] i_dev_pri,
  input  logic [NUM_DEV*VEC_W-1:0] i_dev_vec,
  output logic [NUM_DEV-1:0]       o_ack,
  input  logic [PRI_W-1:0]         i_cpu_pri,
  output logic                     o_irq,
  input  logic                     i_rd,
  output logic [VEC_W-1:0]         o_vec_out,
  output logic [PRI_W-1:0]         o_vec_pri,
  output logic                     o_vec_valid,
  output logic [NUM_DEV-1:0]       o_stall,
  input  logic                     i_stall_clr
);
  localparam int NUM_LVL = 1 << PRI_W;
  localparam int DW      = VEC_W + PRI_W;
  localparam int DEV_W   = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  logic [NUM_DEV-1:0][PRI_W-1:0] w_dpri;
  logic [NUM_DEV-1:0][VEC_W-1:0] w_dvec;
  logic [NUM_LVL-1:0][DW-1:0]    w_head;
  logic [NUM_LVL-1:0]            w_empty, w_full, w_push, w_pop, w_can;
  logic [NUM_DEV-1:0]            w_pend, w_elig, w_block, w_gnt_oh;
  logic [DEV_W-1:0]              w_gnt_idx;
  logic                          w_gnt_any;
  logic [PRI_W-1:0]              w_pop_sel;
  logic                          w_pop_any;
  logic [DW-1:0]                 w_wdata;
  logic                          w_irq_nxt;

  logic [NUM_DEV-1:0] r_arm, r_ack, r_stall;
  logic               r_irq, r_vvld;
  logic [VEC_W-1:0]   r_vec;
  logic [PRI_W-1:0]   r_vpri;

  assign w_dpri = i_dev_pri;
  assign w_dvec = i_dev_vec;
  assign w_pend = i_req & r_arm;

  // Pop target is chosen from pre-push occupancy, giving the one-cycle fall-through.
  always_comb begin
    w_pop_sel = '0;
    for (int p = 0; p < NUM_LVL; p++)
      if (!w_empty[p]) w_pop_sel = PRI_W'(p);
    w_pop_any = i_rd && !(&w_empty);
    w_pop     = w_pop_any ? (NUM_LVL'(1) << w_pop_sel) : '0;
    w_can     = ~w_full | w_pop;
  end

  always_comb begin
    w_elig  = '0;
    w_block = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      w_elig[i]  = w_pend[i] &&  w_can[w_dpri[i]];
      w_block[i] = w_pend[i] && !w_can[w_dpri[i]];
    end
  end

  // Lowest-index eligible device wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (!w_gnt_any && w_elig[i]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = DEV_W'(i);
      end
    end
    w_gnt_oh = w_gnt_any ? (NUM_DEV'(1) << w_gnt_idx) : '0;
    w_push   = w_gnt_any ? (NUM_LVL'(1) << w_dpri[w_gnt_idx]) : '0;
    w_wdata  = {w_dvec[w_gnt_idx], w_dpri[w_gnt_idx]};
  end

  for (genvar p = 0; p < NUM_LVL; p++) begin : g_lvl
    int_pri_queue_fifo #(
      .DEPTH (DEPTH),
      .DW    (DW)
    ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push[p]),
      .i_wdata (w_wdata),
      .i_pop   (w_pop[p]),
      .o_rdata (w_head[p]),
      .o_empty (w_empty[p]),
      .o_full  (w_full[p])
    );
  end

  always_comb begin
    w_irq_nxt = 1'b0;
    for (int p = 0; p < NUM_LVL; p++)
      if (!w_empty[p] && (PRI_W'(p) > i_cpu_pri)) w_irq_nxt = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_arm   <= '1;
      r_ack   <= '0;
      r_stall <= '0;
      r_irq   <= 1'b0;
      r_vvld  <= 1'b0;
      r_vec   <= '0;
      r_vpri  <= '0;
    end else begin
      r_ack   <= w_gnt_oh;
      // Re-arm only once the level request has been seen low.
      r_arm   <= (r_arm & ~w_gnt_oh) | ~i_req;
      r_stall <= i_stall_clr ? '0 : (r_stall | w_block);
      r_irq   <= w_irq_nxt;
      r_vvld  <= w_pop_any;
      if (w_pop_any) {r_vec, r_vpri} <= w_head[w_pop_sel];
    end
  end

  assign o_ack       = r_ack;
  assign o_stall     = r_stall;
  assign o_irq       = r_irq;
  assign o_vec_valid = r_vvld;
  assign o_vec_out   = r_vec;
  assign o_vec_pri   = r_vpri;
endmodule

// File: tb/tb_int_pri_queue_ctrl.sv
// Directed bench for int_pri_queue_ctrl: ack timing, ordering, contention, re-arm,
// full-FIFO stall, masking and asynchronous reset.

module tb_int_pri_queue_ctrl;
  logic        clk, rst_n;
  logic [7:0]  req;
  logic [23:0] dev_pri;
  logic [63:0] dev_vec;
  logic [7:0]  ack;
  logic [2:0]  cpu_pri;
  logic        irq;
  logic        rd;
  logic [7:0]  vec_out;
  logic [2:0]  vec_pri;
  logic        vec_valid;
  logic [7:0]  stall;
  logic        stall_clr;

  int n_cmp = 0;
  int n_err = 0;

  int_pri_queue_ctrl #(
    .NUM_DEV (8),
    .PRI_W   (3),
    .DEPTH   (4),
    .VEC_W   (8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_dev_pri   (dev_pri),
    .i_dev_vec   (dev_vec),
    .o_ack       (ack),
    .i_cpu_pri   (cpu_pri),
    .o_irq       (irq),
    .i_rd        (rd),
    .o_vec_out   (vec_out),
    .o_vec_pri   (vec_pri),
    .o_vec_valid (vec_valid),
    .o_stall     (stall),
    .i_stall_clr (stall_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dev(input int i, input logic [2:0] p, input logic [7:0] v);
    dev_pri[i*3 +: 3] = p;
    dev_vec[i*8 +: 8] = v;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; dev_pri = '0; dev_vec = '0;
    cpu_pri = '0; rd = 1'b0; stall_clr = 1'b0;
    step(); step();
    chk("rst_ack", ack, 0);
    chk("rst_irq", irq, 0);
    chk("rst_vvld", vec_valid, 0);
    chk("rst_vec", vec_out, 0);
    chk("rst_vpri", vec_pri, 0);
    chk("rst_stall", stall, 0);
    rst_n = 1'b1;
    step();

    // Single request
    cpu_pri = 3'd3;
    set_dev(2, 3'd5, 8'hCA);
    req[2] = 1'b1;
    step();
    chk("single_ack", ack, 8'h04);
    req[2] = 1'b0;
    step();
    chk("single_ack_off", ack, 0);
    chk("single_irq", irq, 1);
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("single_vvld", vec_valid, 1);
    chk("single_vec", vec_out, 8'hCA);
    chk("single_vpri", vec_pri, 5);
    step();
    chk("single_vvld_off", vec_valid, 0);
    chk("single_irq_off", irq, 0);
    chk("single_vec_hold", vec_out, 8'hCA);

    // Priority ordering
    set_dev(0, 3'd1, 8'hC2); req[0] = 1'b1;
    step(); chk("ord_ack0", ack, 8'h01); req[0] = 1'b0;
    set_dev(7, 3'd6, 8'hF2); req[7] = 1'b1;
    step(); chk("ord_ack7", ack, 8'h80); req[7] = 1'b0;
    set_dev(3, 3'd6, 8'hCE); req[3] = 1'b1;
    step(); chk("ord_ack3", ack, 8'h08); req[3] = 1'b0;
    rd = 1'b1;
    step(); chk("ord_v1", vec_out, 8'hF2); chk("ord_p1", vec_pri, 6); chk("ord_vv1", vec_valid, 1);
    step(); chk("ord_v2", vec_out, 8'hCE); chk("ord_p2", vec_pri, 6); chk("ord_vv2", vec_valid, 1);
    step(); chk("ord_v3", vec_out, 8'hC2); chk("ord_p3", vec_pri, 1); chk("ord_vv3", vec_valid, 1);
    rd = 1'b0;
    step(); chk("ord_vv_off", vec_valid, 0);

    // Contention: same-cycle requests served lowest index first
    set_dev(1, 3'd4, 8'h11);
    set_dev(4, 3'd4, 8'h44);
    set_dev(6, 3'd3, 8'h66);
    req = 8'b0101_0010;
    step(); chk("cont_ack1", ack, 8'h02); req[1] = 1'b0;
    step(); chk("cont_ack4", ack, 8'h10); req[4] = 1'b0;
    step(); chk("cont_ack6", ack, 8'h40); req[6] = 1'b0;
    step(); chk("cont_ack_off", ack, 0);
    rd = 1'b1;
    step(); chk("cont_v1", vec_out, 8'h11); chk("cont_p1", vec_pri, 4);
    step(); chk("cont_v2", vec_out, 8'h44); chk("cont_p2", vec_pri, 4);
    step(); chk("cont_v3", vec_out, 8'h66); chk("cont_p3", vec_pri, 3);
    rd = 1'b0;
    step();

    // Re-arm: held level gives one ack; a low sample re-arms
    set_dev(5, 3'd2, 8'h55);
    req[5] = 1'b1;
    step(); chk("rearm_ack1", ack, 8'h20);
    for (int k = 0; k < 9; k++) begin
      step(); chk("rearm_hold", ack, 0);
    end
    req[5] = 1'b0;
    step(); chk("rearm_low", ack, 0);
    req[5] = 1'b1;
    step(); chk("rearm_ack2", ack, 8'h20);
    req[5] = 1'b0;
    rd = 1'b1;
    step(); chk("rearm_vv1", vec_valid, 1); chk("rearm_v1", vec_out, 8'h55);
    step(); chk("rearm_vv2", vec_valid, 1); chk("rearm_v2", vec_out, 8'h55);
    step(); chk("rearm_empty_rd", vec_valid, 0);
    rd = 1'b0;
    step();

    // Full FIFO at priority 2
    for (int i = 0; i < 5; i++) set_dev(i, 3'd2, 8'hA0 + 8'(i));
    req = 8'h1F;
    step(); chk("full_ack0", ack, 8'h01); req[0] = 1'b0;
    step(); chk("full_ack1", ack, 8'h02); req[1] = 1'b0;
    step(); chk("full_ack2", ack, 8'h04); req[2] = 1'b0;
    step(); chk("full_ack3", ack, 8'h08); req[3] = 1'b0;
    step(); chk("full_blk_ack", ack, 0); chk("full_stall", stall, 8'h10);
    step(); chk("full_blk_ack2", ack, 0); chk("full_stall2", stall, 8'h10);
    stall_clr = 1'b1;
    step(); chk("clr_wins", stall, 0); chk("clr_ack", ack, 0);
    stall_clr = 1'b0;
    step(); chk("stall_reset", stall, 8'h10);
    rd = 1'b1;
    step();
    chk("full_pop_ack", ack, 8'h10);
    chk("full_pop_vec", vec_out, 8'hA0);
    chk("full_pop_vv", vec_valid, 1);
    chk("full_stall_sticky", stall, 8'h10);
    rd = 1'b0; req[4] = 1'b0;
    stall_clr = 1'b1;
    step(); chk("stall_clr", stall, 0);
    stall_clr = 1'b0;

    // Masking
    cpu_pri = 3'd2;
    step(); step(); chk("mask_irq0", irq, 0);
    cpu_pri = 3'd1;
    step(); chk("mask_irq1", irq, 1);

    // Asynchronous reset mid-queue
    rst_n = 1'b0;
    #1;
    chk("arst_irq", irq, 0);
    chk("arst_vec", vec_out, 0);
    chk("arst_vpri", vec_pri, 0);
    chk("arst_ack", ack, 0);
    chk("arst_vvld", vec_valid, 0);
    chk("arst_stall", stall, 0);
    step(); step();
    rst_n = 1'b1;
    rd = 1'b1;
    step(); chk("post_rst_vv", vec_valid, 0);
    step(); chk("post_rst_vv2", vec_valid, 0); chk("post_rst_irq", irq, 0);
    rd = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
